mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-side memory access controller for the M stage: consumes the memory-control fields produced by the main decoder (memwrite, memtoreg, memsize, memsignext) together with the effective address and store data. It performs alignment checking and store-lane replication, then drives one transaction on the SRAM-like data bus toward the AXI bridge. Read data is extracted and sign- or zero-extended, and the pipeline is stalled until the access completes.

## Interface
Parameters: none. Size encodings are fixed: MEM_BYTE=2'b00, MEM_HALFWORD=2'b01, MEM_WORD=2'b10. The data_size bus encoding is the same.
- clk  in  1  clock; one clock domain, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- op_valid  in  1  M stage holds a valid instruction
- memwrite  in  1  store
- memtoreg  in  1  load
- memsize  in  2  access size
- memsignext  in  1  1 = sign-extend load, 0 = zero-extend
- addr  in  32  effective byte address
- wdata  in  32  store data (rt), right-aligned
- flush  in  1  M-stage exception/flush; cancels this instruction's access
- stall  out  1  hold pipeline
- rdata_out  out  32  aligned and extended load result
- rdata_valid  out  1  rdata_out valid (one-cycle pulse)
- adel / ades  out  1 each  load / store address error
- badvaddr  out  32  = addr when adel or ades
- data_req, data_wr  out  1 each  bus request; 1 = write
- data_size  out  2  bus size
- data_addr, data_wdata  out  32 each  bus address and write data
- data_rdata  in  32  bus read data
- data_addr_ok, data_data_ok  in  1 each  bus accept / bus complete

## Operation
- mem_op = op_valid & (memwrite | memtoreg).
- Misaligned condition: half with addr[0]=1, or word with addr[1:0]≠0.
  - Combinational: adel = mem_op & memtoreg & misaligned; ades = mem_op & memwrite & misaligned.
  - No bus request is issued on a misaligned access.
- Store data lanes: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- data_addr = addr (full byte address).
- Load extraction:
  - Shift data_rdata right by addr[1:0]*8.
  - Take the low 8 or 16 bits.
  - Extend to 32 bits per memsignext.
  - Word loads pass data_rdata through unchanged.
- State machine: IDLE, REQ, WAIT, DONE.
  - IDLE: if mem_op & ~misaligned & ~flush, latch data_wr, data_size, data_addr, data_wdata, addr[1:0], memsignext, memsize, and go to REQ.
  - REQ: data_req=1, with all request fields held stable.
    - flush & ~data_addr_ok → IDLE (request withdrawn).
    - data_addr_ok → WAIT. If flush is high in the same cycle, set drop=1.
  - WAIT: data_req=0. A flush here sets drop=1.
    - On data_data_ok with drop=1 → IDLE, clear drop; result is discarded and rdata_valid stays 0.
    - On data_data_ok with drop=0 → DONE, registering the extended load result (0 for stores) into rdata_out.
  - DONE: rdata_valid=1, stall=0; → IDLE unconditionally. No re-issue occurs even though op_valid is still high.
- stall is high in any of these cases:
  - (IDLE & mem_op & ~misaligned & ~flush)
  - REQ
  - WAIT, including the drop case, which preserves the single-outstanding ordering rule.
- At most one outstanding transaction. data_req is never asserted in WAIT or DONE.

## Timing
- Reset (resetn=0 at an edge):
  - state=IDLE, drop=0.
  - data_req, data_wr, rdata_valid = 0.
  - data_size, data_addr, data_wdata, rdata_out = 0.
  - stall, adel, ades follow inputs combinationally; all are 0 when op_valid=0.
- Reset mid-transaction: the block returns to IDLE. The bus bridge shares resetn, so no stale data_ok is honoured.
- Zero-wait bus (addr_ok in the first REQ cycle, data_ok in the first WAIT cycle):
  - cycle 0 IDLE: stall=1
  - cycle 1 REQ: data_req=1
  - cycle 2 WAIT
  - cycle 3 DONE: stall=0, rdata_valid=1
  - Total: 3 stall cycles.
- Each extra bus wait cycle adds exactly one stall cycle.
- data_req rises only on entry to REQ. It is held until the cycle data_addr_ok is sampled high, then is 0 the next cycle.
- Exceptions (adel/ades): asserted in the same cycle as op_valid, with stall=0.

## Test plan
- Word load, addr=0x8000_0004, zero-wait bus, data_rdata=0x1234_5678 → data_req one cycle with data_size=2'b10; DONE cycle rdata_out=0x1234_5678, rdata_valid=1; stall high exactly 3 cycles.
- LB/LBU, addr=0x...03, data_rdata=0x80AA_BBCC → memsignext=1 gives 0xFFFF_FF80; memsignext=0 gives 0x0000_0080.
- SH, addr=0x...02, wdata=0xDEAD_BEEF → data_wr=1, data_size=2'b01, data_wdata=0xBEEF_BEEF, data_addr=0x...02; addr_ok delayed 2 cycles → fields stable throughout REQ, stall high 5 cycles.
- LW, addr=0x...02 → adel=1, badvaddr=addr, stall=0, data_req never asserted. SW, addr=0x...01 → ades=1.
- Flush cases:
  - Flush while in REQ before addr_ok → IDLE next cycle, data_req drops, rdata_valid never asserted.
  - Flush in WAIT → stall held until data_ok, then IDLE with rdata_valid=0 and rdata_out unchanged.
- resetn=0 during WAIT → next cycle all registered outputs 0, state IDLE; a later load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-side memory access controller for the M stage. Checks alignment,
// replicates store data across byte lanes, runs one transaction on the
// SRAM-like data bus, then extracts and extends the load result. The
// pipeline is stalled until the access completes.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   op_valid                       M stage holds a valid instruction
//   memwrite, memtoreg             store / load
//   memsize, memsignext            access size, sign-extend loads
//   addr, wdata                    effective byte address, store data
//   flush                          cancels this instruction's access
//   stall                          hold pipeline
//   rdata_out, rdata_valid         extended load result, one-cycle pulse
//   adel, ades, badvaddr           address error flags and faulting address
//   data_req, data_wr, data_size   bus request, write flag, size
//   data_addr, data_wdata          bus address and write data
//   data_rdata                     bus read data
//   data_addr_ok, data_data_ok     bus accept / bus complete
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  memsize,
  input  logic        memsignext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam logic [1:0] MEM_BYTE     = 2'b00;
  localparam logic [1:0] MEM_HALFWORD = 2'b01;
  localparam logic [1:0] MEM_WORD     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t      state;
  logic        drop;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_signext;

  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic [31:0] store_lanes;
  logic [15:0] shifted;
  logic [31:0] load_ext;

  // Alignment check and exception flags are purely combinational so the
  // exception is visible in the same cycle as the instruction.
  always_comb begin
    mem_op     = op_valid & (memwrite | memtoreg);
    misaligned = ((memsize == MEM_HALFWORD) & addr[0]) |
                 ((memsize == MEM_WORD) & (addr[1:0] != 2'b00));
    adel       = mem_op & memtoreg & misaligned;
    ades       = mem_op & memwrite & misaligned;
    badvaddr   = (adel | ades) ? addr : 32'h0;
    issue      = (state == S_IDLE) & mem_op & ~misaligned & ~flush;
    stall      = issue | (state == S_REQ) | (state == S_WAIT);
  end

  // Replicate the right-aligned store data into every lane it may land in,
  // so the bus byte strobes derived from address and size pick the right one.
  always_comb begin
    store_lanes = wdata;
    case (memsize)
      MEM_BYTE:     store_lanes = {4{wdata[7:0]}};
      MEM_HALFWORD: store_lanes = {2{wdata[15:0]}};
      default:      store_lanes = wdata;
    endcase
  end

  // Load extraction uses the latched offset/size/sign so the result does
  // not depend on whatever the M stage presents when data_ok arrives.
  // Only the low 16 bits after the lane shift are ever needed.
  always_comb begin
    shifted = data_rdata[15:0];
    case (lat_off)
      2'd0: shifted = data_rdata[15:0];
      2'd1: shifted = data_rdata[23:8];
      2'd2: shifted = data_rdata[31:16];
      2'd3: shifted = {8'h00, data_rdata[31:24]};
      default: shifted = data_rdata[15:0];
    endcase
    load_ext = data_rdata;
    case (lat_size)
      MEM_BYTE:     load_ext = {{24{lat_signext & shifted[7]}}, shifted[7:0]};
      MEM_HALFWORD: load_ext = {{16{lat_signext & shifted[15]}}, shifted};
      default:      load_ext = data_rdata;
    endcase
  end

  // Transaction state machine. All bus request fields are registered on
  // entry to REQ and held until the next request, which keeps them stable
  // while the bridge has not yet accepted. A flush after acceptance cannot
  // cancel the bus access, so it is remembered in drop and the returning
  // data is discarded while stall keeps the pipeline ordered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      drop        <= 1'b0;
      data_req    <= 1'b0;
      data_wr     <= 1'b0;
      data_size   <= 2'b00;
      data_addr   <= 32'h0;
      data_wdata  <= 32'h0;
      rdata_out   <= 32'h0;
      rdata_valid <= 1'b0;
      lat_off     <= 2'b00;
      lat_size    <= 2'b00;
      lat_signext <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rdata_valid <= 1'b0;
          if (issue) begin
            data_req    <= 1'b1;
            data_wr     <= memwrite;
            data_size   <= memsize;
            data_addr   <= addr;
            data_wdata  <= store_lanes;
            lat_off     <= addr[1:0];
            lat_size    <= memsize;
            lat_signext <= memsignext;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            drop     <= flush;
            state    <= S_WAIT;
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (drop | flush) begin
              drop  <= 1'b0;
              state <= S_IDLE;
            end else begin
              rdata_out   <= data_wr ? 32'h0 : load_ext;
              rdata_valid <= 1'b1;
              state       <= S_DONE;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        S_DONE: begin
          rdata_valid <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. A small bus responder
// inside doAccess answers requests with configurable address/data delays;
// expected values are hand-computed constants.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic        memwrite;
  logic        memtoreg;
  logic [1:0]  memsize;
  logic        memsignext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  int assert_count = 0;
  int fail_count   = 0;

  mem_access_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_valid     (op_valid),
    .memwrite     (memwrite),
    .memtoreg     (memtoreg),
    .memsize      (memsize),
    .memsignext   (memsignext),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .stall        (stall),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .adel         (adel),
    .ades         (ades),
    .badvaddr     (badvaddr),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  // Global watchdog so the run always ends even if a wait is never met.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic ld,
                               input logic [1:0] size, input logic sext,
                               input logic [31:0] a, input logic [31:0] wd);
    op_valid   = valid;
    memwrite   = wr;
    memtoreg   = ld;
    memsize    = size;
    memsignext = sext;
    addr       = a;
    wdata      = wd;
    flush      = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one access against a responder that accepts after addr_delay extra
  // REQ cycles and completes after data_delay extra WAIT cycles. Checks the
  // result, stall length, request length, field stability and pulse width.
  task automatic doAccess(input string tag, input logic wr, input logic ld,
                          input logic [1:0] size, input logic sext,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_result, input int addr_delay,
                          input int data_delay);
    int          stall_cnt  = 0;
    int          req_cnt    = 0;
    int          wait_cnt   = 0;
    logic        accepted   = 1'b0;
    logic        data_sent  = 1'b0;
    logic        done       = 1'b0;
    logic        fields_bad = 1'b0;
    logic [31:0] result     = 32'h0;
    data_rdata = rd;
    applyStimulus(1'b1, wr, ld, size, sext, a, wd);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall) stall_cnt++;
      if (rdata_valid) begin
        done   = 1'b1;
        result = rdata_out;
      end
      if (data_req) begin
        req_cnt++;
        if (data_addr !== a || data_wdata !== exp_wdata || data_size !== size || data_wr !== wr)
          fields_bad = 1'b1;
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (accepted && !data_sent) begin
        wait_cnt++;
        if (wait_cnt > data_delay) begin
          data_data_ok = 1'b1;
          data_sent    = 1'b1;
        end
      end
      if (data_req && req_cnt > addr_delay) begin
        data_addr_ok = 1'b1;
        accepted     = 1'b1;
      end
      if (done) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      nextCycle();
    end
    #1;
    checkOutput({tag, "_completed"}, {31'h0, done}, 32'h1);
    checkOutput({tag, "_result"}, result, exp_result);
    checkOutput({tag, "_stall_cycles"}, stall_cnt, 3 + addr_delay + data_delay);
    checkOutput({tag, "_req_cycles"}, req_cnt, 1 + addr_delay);
    checkOutput({tag, "_fields_stable"}, {31'h0, fields_bad}, 32'h0);
    checkOutput({tag, "_valid_pulse"}, {31'h0, rdata_valid}, 32'h0);
  endtask

  initial begin
    logic any_req;
    logic any_valid;
    resetn       = 1'b0;
    data_rdata   = 32'h0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();

    checkOutput("rst_data_req", {31'h0, data_req}, 32'h0);
    checkOutput("rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
    checkOutput("rst_data_addr", data_addr, 32'h0);
    checkOutput("rst_data_size", {30'h0, data_size}, 32'h0);
    checkOutput("rst_rdata_out", rdata_out, 32'h0);
    checkOutput("rst_stall", {31'h0, stall}, 32'h0);
    resetn = 1'b1;
    nextCycle();

    doAccess("lw_zero_wait", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'h0,
             32'h1234_5678, 32'h0, 32'h1234_5678, 0, 0);
    doAccess("lb_signed", 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_1003, 32'h0,
             32'h80AA_BBCC, 32'h0, 32'hFFFF_FF80, 0, 0);
    doAccess("lbu", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0,
             32'h80AA_BBCC, 32'h0, 32'h0000_0080, 0, 1);
    doAccess("lh_signed", 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_1002, 32'h0,
             32'h80AA_BBCC, 32'h0, 32'hFFFF_80AA, 1, 0);

    // Flush in WAIT: response is swallowed and the previous result stays.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    nextCycle();
    data_addr_ok = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flushwait_stall_flush", {31'h0, stall}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("flushwait_stall_held", {31'h0, stall}, 32'h1);
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    nextCycle();
    data_data_ok = 1'b0;
    checkOutput("flushwait_no_valid", {31'h0, rdata_valid}, 32'h0);
    checkOutput("flushwait_rdata_kept", rdata_out, 32'hFFFF_80AA);
    checkOutput("flushwait_stall_off", {31'h0, stall}, 32'h0);
    nextCycle();
    checkOutput("flushwait_no_valid_late", {31'h0, rdata_valid}, 32'h0);

    doAccess("sh_delayed", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF,
             32'h0, 32'hBEEF_BEEF, 32'h0, 2, 0);

    // Misaligned word load and store raise exceptions without a request.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0002, 32'h0);
    #1;
    checkOutput("lw_mis_adel", {31'h0, adel}, 32'h1);
    checkOutput("lw_mis_ades", {31'h0, ades}, 32'h0);
    checkOutput("lw_mis_badvaddr", badvaddr, 32'h8000_0002);
    checkOutput("lw_mis_stall", {31'h0, stall}, 32'h0);
    any_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (data_req) any_req = 1'b1;
    end
    checkOutput("lw_mis_no_req", {31'h0, any_req}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h1111_2222);
    #1;
    checkOutput("sw_mis_ades", {31'h0, ades}, 32'h1);
    checkOutput("sw_mis_adel", {31'h0, adel}, 32'h0);
    checkOutput("sw_mis_badvaddr", badvaddr, 32'h8000_0001);
    checkOutput("sw_mis_stall", {31'h0, stall}, 32'h0);
    nextCycle();
    checkOutput("sw_mis_no_req", {31'h0, data_req}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("idle_no_adel", {31'h0, adel}, 32'h0);

    // Flush in REQ before acceptance withdraws the request.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    #1;
    checkOutput("flushreq_stall_idle", {31'h0, stall}, 32'h1);
    nextCycle();
    checkOutput("flushreq_req_high", {31'h0, data_req}, 32'h1);
    flush = 1'b1;
    #1;
    checkOutput("flushreq_stall_req", {31'h0, stall}, 32'h1);
    nextCycle();
    checkOutput("flushreq_req_dropped", {31'h0, data_req}, 32'h0);
    checkOutput("flushreq_stall_off", {31'h0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    any_req   = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (data_req) any_req = 1'b1;
      if (rdata_valid) any_valid = 1'b1;
    end
    checkOutput("flushreq_no_req_after", {31'h0, any_req}, 32'h0);
    checkOutput("flushreq_no_valid", {31'h0, any_valid}, 32'h0);

    // Reset while waiting for data clears all registered outputs.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    nextCycle();
    data_addr_ok = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    checkOutput("rstwait_in_wait", {31'h0, stall}, 32'h1);
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("rstwait_data_req", {31'h0, data_req}, 32'h0);
    checkOutput("rstwait_data_addr", data_addr, 32'h0);
    checkOutput("rstwait_data_size", {30'h0, data_size}, 32'h0);
    checkOutput("rstwait_rdata_out", rdata_out, 32'h0);
    checkOutput("rstwait_rdata_valid", {31'h0, rdata_valid}, 32'h0);
    checkOutput("rstwait_stall", {31'h0, stall}, 32'h0);
    resetn = 1'b1;
    nextCycle();

    doAccess("lbu_after_reset", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0,
             32'h1122_3344, 32'h0, 32'h0000_0033, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
